// File: rtl/chroni_vram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chroni_vram_responder_pkg
//  Description : Shared types and defaults for the chroni VRAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package chroni_vram_responder_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int LAT_W      = 3;

    typedef enum logic {
        OWNER_VID = 1'b0,
        OWNER_CPU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    // Value loaded into the latency counter when the read strobe is issued.
    function automatic logic [LAT_W-1:0] lat_load(input int latency);
        return LAT_W'(latency - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chroni_vram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : chroni_vram_responder_if
//  Description : Read-port bundle (addr/req/ack/data) shared by video and CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface chroni_vram_responder_if #(
    parameter int ADDR_W = chroni_vram_responder_pkg::DEF_ADDR_W,
    parameter int DATA_W = chroni_vram_responder_pkg::DEF_DATA_W
);
    logic [ADDR_W-1:0] addr;
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (
        output addr,
        output req,
        input  ack,
        input  data
    );

    modport slave (
        input  addr,
        input  req,
        output ack,
        output data
    );
endinterface
`default_nettype wire

// File: rtl/chroni_vram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : chroni_vram_responder
//  Description : Arbitrates video and CPU read ports onto one fixed-latency
//                synchronous memory; one access outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module chroni_vram_responder
    import chroni_vram_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic              sys_clk,
    input  wire logic              reset,
    chroni_vram_responder_if.slave vid,
    chroni_vram_responder_if.slave cpu,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  wire logic [DATA_W-1:0] mem_rdata
);

    state_e             state_q;
    owner_e             owner_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               mem_rd_q;
    logic               vid_ack_q;
    logic               cpu_ack_q;
    logic [DATA_W-1:0]  vid_data_q;
    logic [DATA_W-1:0]  cpu_data_q;
    logic               vid_rel_q;
    logic               cpu_rel_q;

    logic               w_vid_elig;
    logic               w_cpu_elig;

    assign w_vid_elig = vid.req && !vid_rel_q;
    assign w_cpu_elig = cpu.req && !cpu_rel_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_VID;
            lat_cnt_q  <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_data_q <= '0;
            cpu_data_q <= '0;
            vid_rel_q  <= 1'b0;
            cpu_rel_q  <= 1'b0;
        end else begin
            mem_rd_q  <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;

            // A served port stays blocked until its req has been seen low.
            if (!vid.req) begin
                vid_rel_q <= 1'b0;
            end
            if (!cpu.req) begin
                cpu_rel_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_vid_elig) begin
                        owner_q    <= OWNER_VID;
                        mem_addr_q <= vid.addr;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else if (w_cpu_elig) begin
                        owner_q    <= OWNER_CPU;
                        mem_addr_q <= cpu.addr;
                        mem_rd_q   <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    lat_cnt_q <= lat_load(MEM_LATENCY);
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        if (owner_q == OWNER_VID) begin
                            vid_data_q <= mem_rdata;
                            vid_ack_q  <= 1'b1;
                        end else begin
                            cpu_data_q <= mem_rdata;
                            cpu_ack_q  <= 1'b1;
                        end
                        state_q <= ST_ACK;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end

                ST_ACK: begin
                    if (owner_q == OWNER_VID) begin
                        vid_rel_q <= 1'b1;
                    end else begin
                        cpu_rel_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign vid.ack  = vid_ack_q;
    assign vid.data = vid_data_q;
    assign cpu.ack  = cpu_ack_q;
    assign cpu.data = cpu_data_q;

endmodule
`default_nettype wire

// File: tb/tb_chroni_vram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chroni_vram_responder
//  Description : Directed bench; one responder lane per MEM_LATENCY 1..7,
//                each backed by a behavioural fixed-latency ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chroni_vram_responder;

    localparam int NL = 7;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 sys_clk = ~sys_clk;

    logic [12:0]   vid_addr_a [NL];
    logic [12:0]   cpu_addr_a [NL];
    logic [NL-1:0] vid_req_a;
    logic [NL-1:0] cpu_req_a;
    logic [NL-1:0] vid_ack_a;
    logic [NL-1:0] cpu_ack_a;
    logic [7:0]    vid_data_a [NL];
    logic [7:0]    cpu_data_a [NL];
    logic [NL-1:0] mem_rd_a;
    logic [12:0]   mem_addr_a [NL];

    int n_checks = 0;
    int n_errors = 0;

    // ROM contents: mem[0x401]=0x5A, mem[0x0010]=0x6B, mem[0x1FFF]=0x7C.
    function automatic logic [7:0] mem_val(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b000} ^ 8'h7B;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        localparam int L = gi + 1;

        chroni_vram_responder_if #(.ADDR_W(13), .DATA_W(8)) vid_if ();
        chroni_vram_responder_if #(.ADDR_W(13), .DATA_W(8)) cpu_if ();

        logic [12:0] w_mem_addr;
        logic        w_mem_rd;
        logic [7:0]  w_mem_rdata;
        logic [7:0]  pd [L];
        logic [L-1:0] pv;

        assign vid_if.addr    = vid_addr_a[gi];
        assign vid_if.req     = vid_req_a[gi];
        assign cpu_if.addr    = cpu_addr_a[gi];
        assign cpu_if.req     = cpu_req_a[gi];
        assign vid_ack_a[gi]  = vid_if.ack;
        assign vid_data_a[gi] = vid_if.data;
        assign cpu_ack_a[gi]  = cpu_if.ack;
        assign cpu_data_a[gi] = cpu_if.data;
        assign mem_rd_a[gi]   = w_mem_rd;
        assign mem_addr_a[gi] = w_mem_addr;

        chroni_vram_responder #(
            .ADDR_W      (13),
            .DATA_W      (8),
            .MEM_LATENCY (L)
        ) u_dut (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .vid       (vid_if),
            .cpu       (cpu_if),
            .mem_addr  (w_mem_addr),
            .mem_rd    (w_mem_rd),
            .mem_rdata (w_mem_rdata)
        );

        // Memory keeps running through reset so late data really arrives.
        always @(posedge sys_clk) begin
            pd[0] <= mem_val(w_mem_addr);
            pv[0] <= w_mem_rd;
            for (int k = 1; k < L; k++) begin
                pd[k] <= pd[k-1];
                pv[k] <= pv[k-1];
            end
        end

        assign w_mem_rdata = pv[L-1] ? pd[L-1] : 8'hEE;
    end

    int          rd_cnt   = 0;
    int          vack_cnt = 0;
    int          cack_cnt = 0;
    logic [12:0] last_rd_addr = '0;

    always @(negedge sys_clk) begin
        if (mem_rd_a[0]) begin
            rd_cnt++;
            last_rd_addr = mem_addr_a[0];
        end
        if (vid_ack_a[0]) vack_cnt++;
        if (cpu_ack_a[0]) cack_cnt++;
    end

    // Request on one port, measure req-to-ack cycles, then release like a master.
    task automatic do_read(input int ln, input bit is_cpu, input logic [12:0] a,
                           input logic [7:0] exp_d, input int exp_lat, input string tag);
        int   cyc;
        logic ack;
        @(posedge sys_clk); #1;
        if (is_cpu) begin
            cpu_addr_a[ln] = a;
            cpu_req_a[ln]  = 1'b1;
        end else begin
            vid_addr_a[ln] = a;
            vid_req_a[ln]  = 1'b1;
        end
        cyc = 0;
        while (cyc < 40) begin
            @(negedge sys_clk);
            ack = is_cpu ? cpu_ack_a[ln] : vid_ack_a[ln];
            if (ack) break;
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_data"}, is_cpu ? cpu_data_a[ln] : vid_data_a[ln], exp_d);
        @(negedge sys_clk);
        check({tag, "_ackw"}, is_cpu ? cpu_ack_a[ln] : vid_ack_a[ln], 1'b0);
        @(posedge sys_clk); #1;
        if (is_cpu) cpu_req_a[ln] = 1'b0;
        else        vid_req_a[ln] = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, a0, c0, va_cyc, ca_cyc, seen;
        for (int i = 0; i < NL; i++) begin
            vid_addr_a[i] = '0;
            cpu_addr_a[i] = '0;
        end
        vid_req_a = '0;
        cpu_req_a = '0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_vack",  vid_ack_a[0],  1'b0);
        check("rst_cack",  cpu_ack_a[0],  1'b0);
        check("rst_vdata", vid_data_a[0], 8'h00);
        check("rst_cdata", cpu_data_a[0], 8'h00);
        check("rst_maddr", mem_addr_a[0], 13'h0000);
        check("rst_mrd",   mem_rd_a[0],   1'b0);
        reset = 1'b0;

        // Single video read
        r0 = rd_cnt;
        do_read(0, 1'b0, 13'h0401, 8'h5A, 3, "single");
        check("single_rdcnt", rd_cnt - r0, 1);
        check("single_maddr", last_rd_addr, 13'h0401);
        repeat (5) @(negedge sys_clk);
        check("single_hold", vid_data_a[0], 8'h5A);

        // Back-to-back video scan
        r0 = rd_cnt;
        a0 = vack_cnt;
        for (int i = 0; i < 68; i++) begin
            do_read(0, 1'b0, 13'h0401 + 13'(i), mem_val(13'h0401 + 13'(i)), 3, "scan");
        end
        check("scan_rdcnt",  rd_cnt - r0,   68);
        check("scan_ackcnt", vack_cnt - a0, 68);

        // Contention: video first, CPU next, vid_data untouched by CPU access
        a0 = vack_cnt;
        c0 = cack_cnt;
        va_cyc = -1;
        ca_cyc = -1;
        @(posedge sys_clk); #1;
        vid_addr_a[0] = 13'h0010;
        cpu_addr_a[0] = 13'h1FFF;
        vid_req_a[0]  = 1'b1;
        cpu_req_a[0]  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge sys_clk);
            if (vid_ack_a[0] && va_cyc < 0) begin
                va_cyc = c;
                check("cont_vdata", vid_data_a[0], 8'h6B);
                vid_req_a[0] = 1'b0;
            end
            if (cpu_ack_a[0] && ca_cyc < 0) begin
                ca_cyc = c;
                cpu_req_a[0] = 1'b0;
            end
        end
        check("cont_vlat",  va_cyc, 3);
        check("cont_clat",  ca_cyc, 7);
        check("cont_cdata", cpu_data_a[0], 8'h7C);
        check("cont_vhold", vid_data_a[0], 8'h6B);
        check("cont_vacks", vack_cnt - a0, 1);
        check("cont_cacks", cack_cnt - c0, 1);

        // CPU holds req across ack
        c0 = cack_cnt;
        r0 = rd_cnt;
        @(posedge sys_clk); #1;
        cpu_addr_a[0] = 13'h0AB0;
        cpu_req_a[0]  = 1'b1;
        repeat (15) @(negedge sys_clk);
        check("hold_acks",  cack_cnt - c0, 1);
        check("hold_rds",   rd_cnt - r0,   1);
        check("hold_cdata", cpu_data_a[0], 8'h9B);
        @(posedge sys_clk); #1;
        cpu_req_a[0] = 1'b0;
        @(posedge sys_clk); #1;
        cpu_addr_a[0] = 13'h0123;
        cpu_req_a[0]  = 1'b1;
        repeat (8) @(negedge sys_clk);
        check("hold_acks2",  cack_cnt - c0, 2);
        check("hold_rds2",   rd_cnt - r0,   2);
        check("hold_cdata2", cpu_data_a[0], 8'h50);
        check("hold_vhold",  vid_data_a[0], 8'h6B);
        @(posedge sys_clk); #1;
        cpu_req_a[0] = 1'b0;
        @(posedge sys_clk); #1;

        // Reset during WAIT on the MEM_LATENCY=3 lane
        do_read(2, 1'b0, 13'h0777, 8'h34, 5, "rpre");
        @(posedge sys_clk); #1;
        vid_addr_a[2] = 13'h0555;
        vid_req_a[2]  = 1'b1;
        repeat (3) @(negedge sys_clk);
        reset        = 1'b1;
        vid_req_a[2] = 1'b0;
        @(negedge sys_clk);
        check("rmid_vack",  vid_ack_a[2],  1'b0);
        check("rmid_vdata", vid_data_a[2], 8'h00);
        check("rmid_mrd",   mem_rd_a[2],   1'b0);
        check("rmid_maddr", mem_addr_a[2], 13'h0000);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge sys_clk);
            if (vid_ack_a[2]) seen++;
        end
        check("rmid_noack", seen, 0);
        do_read(2, 1'b0, 13'h0555, 8'h06, 5, "rpost");

        // Latency sweep
        for (int l = 1; l <= NL; l++) begin
            do_read(l - 1, 1'b0, 13'h0100 + 13'(l), mem_val(13'h0100 + 13'(l)), l + 2,
                    $sformatf("sweep%0d", l));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
